// File: rtl/tea_pkg.sv
// Shared constants, state encoding and helpers for the iterative TEA engine.
package tea_pkg;

   localparam logic [31:0] DELTA_DEFAULT = 32'h9E3779B9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Key word indices: k0 is the most significant 32 bits of the key.
   localparam int unsigned K0 = 0;
   localparam int unsigned K1 = 1;
   localparam int unsigned K2 = 2;
   localparam int unsigned K3 = 3;

   // Starting sum for decryption: DELTA*ROUNDS, wrapped to 32 bits.
   function automatic logic [31:0] delta_times_rounds(input logic [31:0] delta,
                                                      input int unsigned rounds);
      return delta * 32'(rounds);
   endfunction

   function automatic logic [31:0] key_word(input logic [127:0] key,
                                            input int unsigned idx);
      return key[127 - 32*idx -: 32];
   endfunction

endpackage

// File: rtl/tea_cycle.sv
// One full TEA cycle (two Feistel half-rounds), purely combinational.
module tea_cycle
   import tea_pkg::*;
#(
   parameter logic [31:0] DELTA = DELTA_DEFAULT
) (
   input  logic [31:0]  i_v0,
   input  logic [31:0]  i_v1,
   input  logic [127:0] i_key,
   input  logic [31:0]  i_sum,
   input  logic         i_encrypt,
   output logic [31:0]  o_v0,
   output logic [31:0]  o_v1,
   output logic [31:0]  o_sum
);

   logic [31:0] w_k0, w_k1, w_k2, w_k3;
   logic [31:0] w_s;

   assign w_k0 = key_word(i_key, K0);
   assign w_k1 = key_word(i_key, K1);
   assign w_k2 = key_word(i_key, K2);
   assign w_k3 = key_word(i_key, K3);

   function automatic logic [31:0] f_mix(input logic [31:0] x,
                                         input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [31:0] s);
      return ((x << 4) + a) ^ (x + s) ^ ((x >> 5) + b);
   endfunction

   // Encrypt advances the sum before mixing; decrypt mixes with the current sum then retreats it.
   always_comb begin
      w_s   = i_sum + DELTA;
      o_v0  = i_v0;
      o_v1  = i_v1;
      o_sum = i_sum;
      if (i_encrypt) begin
         o_v0  = i_v0 + f_mix(i_v1, w_k0, w_k1, w_s);
         o_v1  = i_v1 + f_mix(o_v0, w_k2, w_k3, w_s);
         o_sum = w_s;
      end else begin
         o_v1  = i_v1 - f_mix(i_v0, w_k2, w_k3, i_sum);
         o_v0  = i_v0 - f_mix(o_v1, w_k0, w_k1, i_sum);
         o_sum = i_sum - DELTA;
      end
   end

endmodule

// File: rtl/tea_iter_core.sv
// Iterative TEA engine: UNROLL cycles per clock, ROUNDS cycles per block,
// valid/ready handshake on input and output.
module tea_iter_core
   import tea_pkg::*;
#(
   parameter int unsigned ROUNDS = 32,
   parameter int unsigned UNROLL = 1,
   parameter logic [31:0] DELTA  = DELTA_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         encrypt,
   input  logic [127:0] key,
   input  logic [31:0]  in_v0,
   input  logic [31:0]  in_v1,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [31:0]  out_v0,
   output logic [31:0]  out_v1,
   output logic         busy
);

   localparam int unsigned NSTEP    = ROUNDS / UNROLL;
   localparam int unsigned CNT_W    = (NSTEP < 2) ? 1 : $clog2(NSTEP + 1);
   localparam logic [31:0] DEC_SUM0 = delta_times_rounds(DELTA, ROUNDS);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [31:0]        r_sum;
   logic [31:0]        r_v0;
   logic [31:0]        r_v1;
   logic [127:0]       r_key;
   logic               r_enc;
   logic [31:0]        r_out0;
   logic [31:0]        r_out1;

   logic [31:0]        w_v0  [0:UNROLL];
   logic [31:0]        w_v1  [0:UNROLL];
   logic [31:0]        w_sum [0:UNROLL];

   assign w_v0[0]  = r_v0;
   assign w_v1[0]  = r_v1;
   assign w_sum[0] = r_sum;

   for (genvar g = 0; g < UNROLL; g++) begin : g_cycle
      tea_cycle #(
         .DELTA(DELTA)
      ) u_cycle (
         .i_v0      (w_v0[g]),
         .i_v1      (w_v1[g]),
         .i_key     (r_key),
         .i_sum     (w_sum[g]),
         .i_encrypt (r_enc),
         .o_v0      (w_v0[g+1]),
         .o_v1      (w_v1[g+1]),
         .o_sum     (w_sum[g+1])
      );
   end

   // Control FSM plus working state; the result is copied to separate output
   // registers so out_v0/out_v1 stay put while the next block is running.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_v0    <= '0;
         r_v1    <= '0;
         r_key   <= '0;
         r_enc   <= 1'b0;
         r_out0  <= '0;
         r_out1  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_enc   <= encrypt;
                  r_key   <= key;
                  r_v0    <= in_v0;
                  r_v1    <= in_v1;
                  r_sum   <= encrypt ? '0 : DEC_SUM0;
                  r_cnt   <= CNT_W'(NSTEP);
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_v0  <= w_v0[UNROLL];
               r_v1  <= w_v1[UNROLL];
               r_sum <= w_sum[UNROLL];
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_out0  <= w_v0[UNROLL];
                  r_out1  <= w_v1[UNROLL];
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign busy      = (r_state == RUN);
   assign out_valid = (r_state == DONE);
   assign out_v0    = r_out0;
   assign out_v1    = r_out1;

endmodule

// File: tb/tb_tea_iter_core.sv
// Directed bench for tea_iter_core at UNROLL = 1, 2, 4, 8 (ROUNDS = 32).
module tb_tea_iter_core;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   in_valid, in_ready, out_valid, out_ready, busy;
   logic         encrypt;
   logic [127:0] key;
   logic [31:0]  in_v0, in_v1;
   logic [31:0]  out_v0 [4];
   logic [31:0]  out_v1 [4];

   int total = 0;
   int bad   = 0;

   localparam logic [127:0] KA = 128'h0123456789ABCDEFFEDCBA9876543210;
   localparam logic [127:0] KB = 128'h000102030405060708090A0B0C0D0E0F;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      tea_iter_core #(
         .ROUNDS(32),
         .UNROLL(1 << g),
         .DELTA (32'h9E3779B9)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .encrypt   (encrypt),
         .key       (key),
         .in_v0     (in_v0),
         .in_v1     (in_v1),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_v0    (out_v0[g]),
         .out_v1    (out_v1[g]),
         .busy      (busy[g])
      );
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Textbook 32-round TEA, written as the usual C loop.
   function automatic logic [63:0] tea_ref(input bit enc, input logic [127:0] k,
                                           input logic [31:0] a, input logic [31:0] b);
      logic [31:0] y, z, s, k0, k1, k2, k3;
      y = a; z = b;
      k0 = k[127:96]; k1 = k[95:64]; k2 = k[63:32]; k3 = k[31:0];
      if (enc) begin
         s = 32'h0;
         for (int i = 0; i < 32; i++) begin
            s = s + 32'h9E3779B9;
            y = y + (((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1));
            z = z + (((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3));
         end
      end else begin
         s = 32'hC6EF3720;
         for (int i = 0; i < 32; i++) begin
            z = z - (((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3));
            y = y - (((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1));
            s = s - 32'h9E3779B9;
         end
      end
      return {y, z};
   endfunction

   // Called #1 after a rising edge with DUT u idle; returns result, cycles to out_valid, busy cycles.
   task automatic run_block(input int u, input bit enc, input logic [127:0] k,
                            input logic [31:0] a, input logic [31:0] b, input bit toggle,
                            output logic [63:0] res, output int lat, output int bcnt);
      res  = '0;
      lat  = 0;
      bcnt = 0;
      encrypt = enc; key = k; in_v0 = a; in_v1 = b;
      in_valid[u] = 1'b1;
      @(posedge clk); #1;
      in_valid[u] = 1'b0;
      while (!out_valid[u] && lat < 200) begin
         if (busy[u]) bcnt++;
         if (toggle) begin
            key     = {$urandom, $urandom, $urandom, $urandom};
            encrypt = ~encrypt;
            in_v0   = $urandom;
            in_v1   = $urandom;
         end
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid[u]) begin
         total++;
         bad++;
         $display("FAIL timeout: dut %0d out_valid still %b after %0d cycles, required 1", u, out_valid[u], lat);
         return;
      end
      res = {out_v0[u], out_v1[u]};
      out_ready[u] = 1'b1;
      @(posedge clk); #1;
      out_ready[u] = 1'b0;
   endtask

   typedef struct {
      bit           enc;
      logic [127:0] k;
      logic [31:0]  v0;
      logic [31:0]  v1;
      logic [63:0]  exp;
   } vec_t;

   vec_t        tbl [6];
   logic [63:0] res, c, hold, r2;
   int          lat, bcnt, n;

   initial begin
      rst = 1'b1; in_valid = '0; out_ready = '0;
      encrypt = 1'b0; key = '0; in_v0 = '0; in_v1 = '0;

      tbl[0] = '{1'b1, 128'h0, 32'h0, 32'h0, 64'h41EA3A0A_94BAA940};
      tbl[1] = '{1'b0, 128'h0, 32'h41EA3A0A, 32'h94BAA940, 64'h0};
      c      = tea_ref(1'b1, KA, 32'hDEADBEEF, 32'h01234567);
      tbl[2] = '{1'b1, KA, 32'hDEADBEEF, 32'h01234567, c};
      tbl[3] = '{1'b0, KA, c[63:32], c[31:0], 64'hDEADBEEF_01234567};
      tbl[4] = '{1'b1, '1, 32'hFFFFFFFF, 32'hFFFFFFFF, tea_ref(1'b1, '1, 32'hFFFFFFFF, 32'hFFFFFFFF)};
      tbl[5] = '{1'b0, KB, 32'h12345678, 32'h9ABCDEF0, tea_ref(1'b0, KB, 32'h12345678, 32'h9ABCDEF0)};

      repeat (3) @(posedge clk);
      #1;
      check("reset_flags", 64'({out_valid, busy, in_ready}), 64'({4'b0000, 4'b0000, 4'b1111}));
      for (int u = 0; u < 4; u++)
         check($sformatf("reset_out_%0d", u), {out_v0[u], out_v1[u]}, 64'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         run_block(0, tbl[i].enc, tbl[i].k, tbl[i].v0, tbl[i].v1, 1'b0, res, lat, bcnt);
         check($sformatf("vec%0d_result", i), res, tbl[i].exp);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
         check($sformatf("vec%0d_busy", i), 64'(bcnt), 64'd32);
      end

      for (int u = 0; u < 4; u++) begin
         run_block(u, 1'b1, KA, 32'hDEADBEEF, 32'h01234567, 1'b0, c, lat, bcnt);
         check($sformatf("rt_enc_u%0d", u), c, tea_ref(1'b1, KA, 32'hDEADBEEF, 32'h01234567));
         check($sformatf("rt_lat_u%0d", u), 64'(lat), 64'(32 >> u));
         run_block(u, 1'b0, KA, c[63:32], c[31:0], 1'b0, res, lat, bcnt);
         check($sformatf("rt_dec_u%0d", u), res, 64'hDEADBEEF_01234567);
         check($sformatf("rt_ready_u%0d", u), 64'(in_ready[u]), 64'd1);
      end

      // Backpressure: stall in DONE with a second block offered the whole time.
      encrypt = 1'b1; key = KA; in_v0 = 32'h1; in_v1 = 32'h2;
      in_valid[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      n = 0;
      while (!out_valid[0] && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("bp_done", 64'(out_valid[0]), 64'd1);
      hold = {out_v0[0], out_v1[0]};
      check("bp_first", hold, tea_ref(1'b1, KA, 32'h1, 32'h2));
      encrypt = 1'b0; key = KB; in_v0 = 32'h3; in_v1 = 32'h4;
      in_valid[0] = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         check("bp_hold", {out_v0[0], out_v1[0]}, hold);
         check("bp_flags", 64'({out_valid[0], in_ready[0], busy[0]}), 64'(3'b100));
      end
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      out_ready[0] = 1'b0;
      check("bp_idle", 64'({out_valid[0], in_ready[0], busy[0]}), 64'(3'b010));
      check("bp_keep", {out_v0[0], out_v1[0]}, hold);
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      check("bp_accept2", 64'(busy[0]), 64'd1);
      n = 0;
      while (!out_valid[0] && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("bp_second", {out_v0[0], out_v1[0]}, tea_ref(1'b0, KB, 32'h3, 32'h4));
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      out_ready[0] = 1'b0;

      // Asynchronous reset in the middle of a run, asserted between clock edges.
      encrypt = 1'b1; key = KB; in_v0 = 32'h5; in_v1 = 32'h6;
      in_valid[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      repeat (9) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_flags", 64'({out_valid[0], busy[0], in_ready[0]}), 64'(3'b001));
      check("arst_out", {out_v0[0], out_v1[0]}, 64'h0);
      #3;
      rst = 1'b0;
      @(posedge clk); #1;
      run_block(0, 1'b1, KB, 32'h5, 32'h6, 1'b0, res, lat, bcnt);
      check("arst_fresh", res, tea_ref(1'b1, KB, 32'h5, 32'h6));
      check("arst_lat", 64'(lat), 64'd32);

      // Inputs churn every cycle while running; the latched values must win.
      run_block(0, 1'b1, KA, 32'hDEADBEEF, 32'h01234567, 1'b1, res, lat, bcnt);
      check("toggle_enc", res, tea_ref(1'b1, KA, 32'hDEADBEEF, 32'h01234567));
      run_block(2, 1'b0, KB, 32'hCAFEF00D, 32'h0BADC0DE, 1'b1, res, lat, bcnt);
      check("toggle_dec_u4", res, tea_ref(1'b0, KB, 32'hCAFEF00D, 32'h0BADC0DE));
      check("toggle_lat_u4", 64'(lat), 64'd8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tea_iter_core.md
Name: tea_iter_core

Overview:
- Iterative, parametrised TEA block cipher engine; one 64-bit block per transaction, encrypt or decrypt selected per block.
- Runs UNROLL full TEA cycles per clock over ROUNDS cycles total.
- Generates the round sum internally, latches key, data and mode on acceptance, and uses valid/ready handshakes on both sides.
- Sits between the host data path and the key store, replacing single-cycle combinational round instances.

Parameters:
- ROUNDS, 32, total TEA cycles per block; each cycle is two Feistel half-rounds. Must be ≥1 and divisible by UNROLL.
- UNROLL, 1, TEA cycles computed per clock; allowed values 1, 2, 4, 8.
- DELTA, 32'h9E3779B9, key-schedule constant.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  block offered.
- in_ready  out  1  engine can accept a block.
- encrypt  in  1  1 = encrypt, 0 = decrypt; sampled at acceptance.
- key  in  128  key; k0=key[127:96], k1=key[95:64], k2=key[63:32], k3=key[31:0]; sampled at acceptance.
- in_v0  in  32  first data word.
- in_v1  in  32  second data word.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_v0  out  32  result first word.
- out_v1  out  32  result second word.
- busy  out  1  high in RUN state.

Behaviour:
- Reset (async assert):
  - State goes to IDLE.
  - out_valid=0, busy=0, out_v0=out_v1=0.
  - Internal sum and round counter cleared.
  - A block in flight is discarded with no output.
- States: IDLE, RUN, DONE.
  - in_ready = (state==IDLE); busy = (state==RUN); out_valid = (state==DONE).
- IDLE:
  - in_valid=1 at an edge latches encrypt, key, v0, v1.
  - Sum register loads 0 for encrypt, or DELTA*ROUNDS mod 2^32 for decrypt (a constant, computed at elaboration).
  - Round counter loads ROUNDS/UNROLL; go to RUN.
- RUN: each edge applies UNROLL TEA cycles, decrements the counter, and moves to DONE when the counter reaches 1.
- Latency: the acceptance edge is T0 and out_valid rises after edge T(ROUNDS/UNROLL). The default is 32 clocks.
- F(x,a,b,s) = ((x<<4)+a) ^ (x+s) ^ ((x>>5)+b). Logical shifts; all arithmetic is 32-bit and wraps mod 2^32.
- Encrypt cycle:
  - s = sum+DELTA
  - v0 += F(v1,k0,k1,s)
  - v1 += F(v0_new,k2,k3,s)
  - sum = s
- Decrypt cycle, using the current sum:
  - v1 -= F(v0,k2,k3,sum)
  - v0 -= F(v1_new,k0,k1,sum)
  - sum -= DELTA
- Within one clock, unrolled cycles chain combinationally, each using the previous cycle's results and sum.
- DONE:
  - out_v0/out_v1 hold the result stable while out_valid=1, independent of in_* activity.
  - out_ready=1 at an edge returns the engine to IDLE; in_ready rises the next cycle.
  - With no out_ready, the engine stalls indefinitely.
- Inputs are ignored outside IDLE; in_valid while not ready is not queued.
- Changing key or encrypt during RUN has no effect on the block in flight.
- out_v0/out_v1 keep their last value after consumption, until the next DONE.

Decomposition:
- Package tea_pkg:
  - DELTA default.
  - State enum {IDLE, RUN, DONE}.
  - Key-word index constants K0..K3.
  - Constant function for DELTA*ROUNDS.
- Sub-module tea_cycle: combinational. Inputs v0, v1, key, sum, encrypt. Outputs v0', v1', sum'.
  - Instantiated UNROLL times in a generate chain.

Test Plan:
- Known vector: key=0, v=(0,0), encrypt, ROUNDS=32 → out=(32'h41EA3A0A, 32'h94BAA940) after exactly 32 cycles of busy.
- Decrypt of that result with key=0 → out=(0,0).
- Round trip with key=128'h0123456789ABCDEFFEDCBA9876543210, v=(32'hDEADBEEF, 32'h01234567): encrypt then decrypt returns the input. Repeat for UNROLL=1, 2, 4, 8; latency is 32/UNROLL.
- Backpressure: hold out_ready=0 for 50 cycles in DONE → outputs stable, in_ready=0, second in_valid ignored. Release → IDLE, then the second block is accepted.
- Assert rst at cycle 10 of RUN → out_valid=0 and outputs=0 immediately, without waiting for a clock edge. After deassert, a fresh block gives the correct result.
- Toggle key/encrypt inputs every cycle during RUN → result equals that of the values latched at acceptance.
